// File: rtl/pe_mult_float_pipe.sv
// Three-stage pipelined floating-point multiplier (generic exponent/mantissa widths) with
// round-to-nearest-even, DAZ/FTZ, special-value handling and per-result status flags.
module pe_mult_float_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_W+MANT_W:0] a,
    input  logic [EXP_W+MANT_W:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MANT_W:0] m,
    output logic [3:0]            flags
);
    localparam int W  = 1 + EXP_W + MANT_W;
    localparam int EW = EXP_W + 2;
    localparam int SW = MANT_W + 1;
    localparam int PW = 2 * SW;
    localparam logic [EW-1:0]    BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

    // Whole pipeline stalls as one unit while the output register is held.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic [W-1:0]     op      [2];
    logic [EXP_W-1:0] op_exp  [2];
    logic [SW-1:0]    op_sig  [2];
    logic [1:0]       op_sign;
    logic [1:0]       op_zero;
    logic [1:0]       op_inf;
    logic [1:0]       op_nan;

    assign op[0] = a;
    assign op[1] = b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [MANT_W-1:0] frac;
            assign frac        = op[gi][MANT_W-1:0];
            assign op_sign[gi] = op[gi][W-1];
            assign op_exp[gi]  = op[gi][W-2:MANT_W];
            // Subnormals classify as zero (denormals-are-zero).
            assign op_zero[gi] = (op_exp[gi] == '0);
            assign op_inf[gi]  = (op_exp[gi] == EXP_ONES) && (frac == '0);
            assign op_nan[gi]  = (op_exp[gi] == EXP_ONES) && (frac != '0);
            assign op_sig[gi]  = {1'b1, frac};
        end
    endgenerate

    // Stage 1: classify, sign, biased exponent sum
    logic          s1_sign_next;
    logic          s1_invalid_next;
    logic          s1_inf_next;
    logic          s1_zero_next;
    logic [EW-1:0] s1_exp_next;

    always_comb begin
        s1_sign_next    = op_sign[0] ^ op_sign[1];
        s1_invalid_next = (|op_nan) || (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]);
        s1_inf_next     = |op_inf;
        s1_zero_next    = |op_zero;
        s1_exp_next     = {2'b00, op_exp[0]} + {2'b00, op_exp[1]} - BIAS;
    end

    logic          s1_valid_reg;
    logic          s1_sign_reg;
    logic          s1_invalid_reg;
    logic          s1_inf_reg;
    logic          s1_zero_reg;
    logic [EW-1:0] s1_exp_reg;
    logic [SW-1:0] s1_sig_a_reg;
    logic [SW-1:0] s1_sig_b_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_sign_reg    <= 1'b0;
            s1_invalid_reg <= 1'b0;
            s1_inf_reg     <= 1'b0;
            s1_zero_reg    <= 1'b0;
            s1_exp_reg     <= '0;
            s1_sig_a_reg   <= '0;
            s1_sig_b_reg   <= '0;
        end else if (advance) begin
            s1_valid_reg   <= in_valid;
            s1_sign_reg    <= s1_sign_next;
            s1_invalid_reg <= s1_invalid_next;
            s1_inf_reg     <= s1_inf_next;
            s1_zero_reg    <= s1_zero_next;
            s1_exp_reg     <= s1_exp_next;
            s1_sig_a_reg   <= op_sig[0];
            s1_sig_b_reg   <= op_sig[1];
        end
    end

    // Stage 2: full significand product
    logic [PW-1:0] s2_prod_next;
    assign s2_prod_next = PW'(s1_sig_a_reg) * PW'(s1_sig_b_reg);

    logic          s2_valid_reg;
    logic          s2_sign_reg;
    logic          s2_invalid_reg;
    logic          s2_inf_reg;
    logic          s2_zero_reg;
    logic [EW-1:0] s2_exp_reg;
    logic [PW-1:0] s2_prod_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg   <= 1'b0;
            s2_sign_reg    <= 1'b0;
            s2_invalid_reg <= 1'b0;
            s2_inf_reg     <= 1'b0;
            s2_zero_reg    <= 1'b0;
            s2_exp_reg     <= '0;
            s2_prod_reg    <= '0;
        end else if (advance) begin
            s2_valid_reg   <= s1_valid_reg;
            s2_sign_reg    <= s1_sign_reg;
            s2_invalid_reg <= s1_invalid_reg;
            s2_inf_reg     <= s1_inf_reg;
            s2_zero_reg    <= s1_zero_reg;
            s2_exp_reg     <= s1_exp_reg;
            s2_prod_reg    <= s2_prod_next;
        end
    end

    // Stage 3: normalise, round to nearest even, range check, pack
    logic              norm_hi;
    logic              guard_bit;
    logic              sticky_bit;
    logic              round_up;
    logic              inexact;
    logic              exp_ovf;
    logic              exp_unf;
    logic [MANT_W-1:0] mant_keep;
    logic [MANT_W-1:0] mant_fin;
    logic [MANT_W:0]   mant_rnd;
    logic [EW-1:0]     exp_adj;
    logic [EW-1:0]     exp_fin;
    logic [W-1:0]      m_next;
    logic [3:0]        flags_next;

    always_comb begin
        norm_hi = s2_prod_reg[PW-1];
        if (norm_hi) begin
            mant_keep  = s2_prod_reg[PW-2 -: MANT_W];
            guard_bit  = s2_prod_reg[MANT_W];
            sticky_bit = |s2_prod_reg[MANT_W-1:0];
            exp_adj    = s2_exp_reg + EW'(1);
        end else begin
            mant_keep  = s2_prod_reg[PW-3 -: MANT_W];
            guard_bit  = s2_prod_reg[MANT_W-1];
            sticky_bit = |s2_prod_reg[MANT_W-2:0];
            exp_adj    = s2_exp_reg;
        end

        round_up = guard_bit && (sticky_bit || mant_keep[0]);
        inexact  = guard_bit || sticky_bit;
        mant_rnd = {1'b0, mant_keep} + {{MANT_W{1'b0}}, round_up};

        // Rounding past all-ones mantissa renormalises to the next binade.
        if (mant_rnd[MANT_W]) begin
            mant_fin = '0;
            exp_fin  = exp_adj + EW'(1);
        end else begin
            mant_fin = mant_rnd[MANT_W-1:0];
            exp_fin  = exp_adj;
        end

        exp_unf = exp_fin[EW-1] || (exp_fin == '0);
        exp_ovf = !exp_fin[EW-1] && (exp_fin[EW-2:0] >= {1'b0, EXP_ONES});

        if (s2_invalid_reg) begin
            m_next     = QNAN;
            flags_next = 4'b1000;
        end else if (s2_inf_reg) begin
            m_next     = {s2_sign_reg, EXP_ONES, {MANT_W{1'b0}}};
            flags_next = 4'b0000;
        end else if (s2_zero_reg) begin
            m_next     = {s2_sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0000;
        end else if (exp_ovf) begin
            m_next     = {s2_sign_reg, EXP_ONES, {MANT_W{1'b0}}};
            flags_next = 4'b0101;
        end else if (exp_unf) begin
            m_next     = {s2_sign_reg, {(W-1){1'b0}}};
            flags_next = 4'b0011;
        end else begin
            m_next     = {s2_sign_reg, exp_fin[EXP_W-1:0], mant_fin};
            flags_next = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            m         <= '0;
            flags     <= 4'b0000;
        end else if (advance) begin
            out_valid <= s2_valid_reg;
            m         <= s2_valid_reg ? m_next : '0;
            flags     <= s2_valid_reg ? flags_next : 4'b0000;
        end
    end

endmodule

// File: tb/tb_pe_mult_float_pipe.sv
// Scoreboard bench for pe_mult_float_pipe: fp32 and fp16 instances, directed vectors from
// known values plus random operands checked against an arithmetic reference model.
module tb_pe_mult_float_pipe;

    typedef struct {
        logic [31:0] m;
        logic [3:0]  f;
        int          cyc;
        logic        lat;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid32, in_ready32, out_valid32, out_ready32;
    logic [31:0] a32, b32, m32;
    logic [3:0]  flags32;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16, m16;
    logic [3:0]  flags16;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   rdy_mode = 0;
    logic lat_en = 1'b0;
    exp_t q32[$];
    exp_t q16[$];

    pe_mult_float_pipe #(.EXP_W(8), .MANT_W(23)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .out_valid(out_valid32), .out_ready(out_ready32),
        .m(m32), .flags(flags32)
    );

    pe_mult_float_pipe #(.EXP_W(5), .MANT_W(10)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .m(m16), .flags(flags16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Exact integer product rounded to nearest-even by remainder comparison against half an ulp.
    function automatic void ref_mul(input int ew, input int mw, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] m,
                                    output logic [3:0] fl);
        longint ones, bias, one_m, ea, eb, ma, mb, s, p, q, rem, half, e;
        int sh;
        logic an, bn, ai, bi, az, bz;
        ones  = (longint'(1) << ew) - 1;
        bias  = (longint'(1) << (ew - 1)) - 1;
        one_m = longint'(1) << mw;
        ea = (longint'(a) >> mw) & ones;
        eb = (longint'(b) >> mw) & ones;
        ma = longint'(a) & (one_m - 1);
        mb = longint'(b) & (one_m - 1);
        s  = ((longint'(a) >> (ew + mw)) ^ (longint'(b) >> (ew + mw))) & 1;
        an = (ea == ones) && (ma != 0);
        bn = (eb == ones) && (mb != 0);
        ai = (ea == ones) && (ma == 0);
        bi = (eb == ones) && (mb == 0);
        az = (ea == 0);
        bz = (eb == 0);
        fl = 4'b0000;
        if (an || bn || (ai && bz) || (bi && az)) begin
            m  = 32'((ones << mw) | (one_m >> 1));
            fl = 4'b1000;
        end else if (ai || bi) begin
            m = 32'((s << (ew + mw)) | (ones << mw));
        end else if (az || bz) begin
            m = 32'(s << (ew + mw));
        end else begin
            p  = (one_m + ma) * (one_m + mb);
            sh = (p >= 2 * one_m * one_m) ? mw + 1 : mw;
            e  = ea + eb - bias + longint'(sh - mw);
            q  = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q & 1) == 1)) q = q + 1;
            if (q == 2 * one_m) begin
                q = one_m;
                e = e + 1;
            end
            if (e >= ones) begin
                m  = 32'((s << (ew + mw)) | (ones << mw));
                fl = 4'b0101;
            end else if (e <= 0) begin
                m  = 32'(s << (ew + mw));
                fl = 4'b0011;
            end else begin
                m  = 32'((s << (ew + mw)) | (e << mw) | (q - one_m));
                fl = {3'b000, rem != 0};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op(input int ew, input int mw);
        longint ones, bias, e, f, s;
        int kind;
        ones = (longint'(1) << ew) - 1;
        bias = (longint'(1) << (ew - 1)) - 1;
        kind = int'($urandom_range(0, 15));
        s = longint'($urandom_range(0, 1));
        f = longint'($urandom) & ((longint'(1) << mw) - 1);
        case (kind)
            0: e = 0;
            1: begin e = ones; f = 0; end
            2: begin e = ones; if (f == 0) f = 1; end
            3: e = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(1, 3))
                                              : ones - longint'($urandom_range(1, 3));
            4: e = longint'($urandom_range(1, 32'(ones - 1)));
            5: begin
                e = bias - 2 + longint'($urandom_range(0, 4));
                f = f & ~((longint'(1) << (mw / 2)) - 1);
            end
            default: e = bias - 8 + longint'($urandom_range(0, 16));
        endcase
        return 32'((s << (ew + mw)) | (e << mw) | f);
    endfunction

    always @(negedge clk) begin
        if (stall_cnt > 0) begin
            out_ready32 = 1'b0;
            stall_cnt = stall_cnt - 1;
        end else if (rdy_mode == 1) begin
            out_ready32 = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready32 = 1'b1;
        end
    end

    task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic directed,
                          input logic [31:0] dm, input logic [3:0] df);
        exp_t e;
        logic [31:0] rm;
        logic [3:0] rf;
        logic acc;
        if (directed) begin
            rm = dm;
            rf = df;
        end else begin
            ref_mul(8, 23, x, y, rm, rf);
        end
        e.m = rm;
        e.f = rf;
        e.lat = lat_en;
        e.cyc = 0;
        acc = 1'b0;
        in_valid32 = 1'b1;
        a32 = x;
        b32 = y;
        for (int t = 0; t < 100 && !acc; t++) begin
            #1;
            if (in_ready32) begin
                e.cyc = cyc;
                q32.push_back(e);
                acc = 1'b1;
            end
            @(negedge clk);
        end
        in_valid32 = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send32_timeout: in_ready=0 for 100 cycles, required 1");
        end
    endtask

    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic directed,
                          input logic [15:0] dm, input logic [3:0] df);
        exp_t e;
        logic [31:0] rm;
        logic [3:0] rf;
        logic acc;
        if (directed) begin
            rm = {16'h0, dm};
            rf = df;
        end else begin
            ref_mul(5, 10, {16'h0, x}, {16'h0, y}, rm, rf);
        end
        e.m = rm;
        e.f = rf;
        e.lat = 1'b1;
        e.cyc = 0;
        acc = 1'b0;
        in_valid16 = 1'b1;
        a16 = x;
        b16 = y;
        for (int t = 0; t < 100 && !acc; t++) begin
            #1;
            if (in_ready16) begin
                e.cyc = cyc;
                q16.push_back(e);
                acc = 1'b1;
            end
            @(negedge clk);
        end
        in_valid16 = 1'b0;
        if (!acc) begin
            n_checks++;
            n_errors++;
            $display("FAIL send16_timeout: in_ready=0 for 100 cycles, required 1");
        end
    endtask

    logic        held32 = 1'b0;
    logic [31:0] hold_m32;
    logic [3:0]  hold_f32;

    always @(negedge clk) begin : mon32
        exp_t e;
        #2;
        if (!rst_n) begin
            held32 = 1'b0;
        end else begin
            check("in_ready32", 64'(in_ready32), 64'(!out_valid32 || out_ready32));
            if (!out_valid32) check("idle_flags32", 64'(flags32), 64'd0);
            if (held32) begin
                check("stall_valid32", 64'(out_valid32), 64'd1);
                check("stall_m32", 64'(m32), 64'(hold_m32));
                check("stall_flags32", 64'(flags32), 64'(hold_f32));
            end
            held32   = out_valid32 && !out_ready32;
            hold_m32 = m32;
            hold_f32 = flags32;
            if (out_valid32 && out_ready32) begin
                if (q32.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious32: out_valid=1 m=%h, required no result", m32);
                end else begin
                    e = q32.pop_front();
                    $display("txn32 m=%h flags=%b (expected m=%h flags=%b)", m32, flags32, e.m, e.f);
                    check("m32", 64'(m32), 64'(e.m));
                    check("flags32", 64'(flags32), 64'(e.f));
                    if (e.lat) check("latency32", 64'(cyc - e.cyc), 64'd3);
                end
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        #2;
        if (rst_n) begin
            if (!out_valid16) check("idle_flags16", 64'(flags16), 64'd0);
            if (out_valid16) begin
                if (q16.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious16: out_valid=1 m=%h, required no result", m16);
                end else begin
                    e = q16.pop_front();
                    $display("txn16 m=%h flags=%b (expected m=%h flags=%b)", m16, flags16, e.m[15:0], e.f);
                    check("m16", 64'(m16), 64'(e.m));
                    check("flags16", 64'(flags16), 64'(e.f));
                    check("latency16", 64'(cyc - e.cyc), 64'd3);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q32.size() != 0 || q16.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (q32.size() != 0 || q16.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d/%0d results outstanding, required 0", q32.size(), q16.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid32 = 1'b0;
        in_valid16 = 1'b0;
        a32 = '0;
        b32 = '0;
        a16 = '0;
        b16 = '0;
        out_ready16 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid32", 64'(out_valid32), 64'd0);
        check("reset_m32", 64'(m32), 64'd0);
        check("reset_flags32", 64'(flags32), 64'd0);
        check("reset_out_valid16", 64'(out_valid16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        lat_en = 1'b1;
        send32(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'b0000);
        idle(4);
        send32(32'h3F800001, 32'h3F800001, 1'b1, 32'h3F800002, 4'b0001);
        send32(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40100000, 4'b0000);
        send32(32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00002, 4'b0001);
        send32(32'h3F800003, 32'h3FC00000, 1'b1, 32'h3FC00004, 4'b0001);
        send32(32'h7F000000, 32'h40000000, 1'b1, 32'h7F800000, 4'b0101);
        send32(32'h00800000, 32'h3F000000, 1'b1, 32'h00000000, 4'b0011);
        send32(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, 4'b1000);
        send32(32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 4'b0000);
        send32(32'h80000000, 32'h40400000, 1'b1, 32'h80000000, 4'b0000);
        drain();
        lat_en = 1'b0;

        send16(16'h4000, 16'h4200, 1'b1, 16'h4600, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            send16(16'(rand_op(5, 10)), 16'(rand_op(5, 10)), 1'b0, 16'h0, 4'b0000);
        end
        drain();

        for (int i = 0; i < 8; i++) begin
            if (i == 4) stall_cnt = 5;
            send32(rand_op(8, 23), rand_op(8, 23), 1'b0, 32'h0, 4'b0000);
        end
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            send32(rand_op(8, 23), rand_op(8, 23), 1'b0, 32'h0, 4'b0000);
            if ($urandom_range(0, 3) == 0) idle(1 + int'($urandom_range(0, 2)));
        end
        rdy_mode = 0;
        drain();

        for (int i = 0; i < 3; i++) begin
            send32(rand_op(8, 23), rand_op(8, 23), 1'b0, 32'h0, 4'b0000);
        end
        rst_n = 1'b0;
        q32.delete();
        q16.delete();
        #1;
        check("inflight_reset_out_valid", 64'(out_valid32), 64'd0);
        check("inflight_reset_m", 64'(m32), 64'd0);
        check("inflight_reset_flags", 64'(flags32), 64'd0);
        idle(2);
        rst_n = 1'b1;
        idle(10);
        lat_en = 1'b1;
        send32(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'b0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
